decode_unit_param: RTL and testbench
====================================

DECODE_UNIT_PARAM -- requirements
Module: decode_unit_param

Interface
REQ-001 SHALL have parameter DW, default 16: data and immediate width in bits (>=4).
REQ-002 SHALL have parameter NREGS, default 8: register-file depth (power of two, >=2); AW = $clog2(NREGS), derived.
REQ-003 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port in_valid  in  1  instruction present.
REQ-006 SHALL have port in_ready  out  1  instruction accepted this cycle when high with in_valid.
REQ-007 SHALL have port opcode  in  3  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 OUT, 7 SRST.
REQ-008 SHALL have ports src1, src2, dst  in  AW each  source and destination register addresses.
REQ-009 SHALL have port imm  in  DW  immediate operand.
REQ-010 SHALL have ports wb_en  in  1, wb_dst  in  AW, wb_data  in  DW  writeback request.
REQ-011 SHALL have port out_valid  out  1  ID/EX register holds a valid instruction.
REQ-012 SHALL have port out_ready  in  1  downstream consumes ID/EX contents.
REQ-013 SHALL have ports out_dat1, out_dat2  out  DW  operands; out_dst  out  AW; out_aluop  out  2  (0 add, 1 sub, 2 and, 3 or).
REQ-014 SHALL have ports out_wr_en  out  1, out_dataoutv  out  1  downstream write and output-valid flags.
REQ-015 SHALL have ports stalled  out  1, internal_reset  out  1.

Function
REQ-016 Decode SHALL be: ADD/SUB/AND/OR -> aluop 0/1/2/3, wr_en 1, use src1+src2; ADDI -> aluop 0, dat2=imm, wr_en 1, uses src1; OUT -> aluop 3, dat2=0, wr_en 0, dataoutv 1, uses src1; NOP -> uses nothing.
REQ-017 Operand read SHALL bypass writeback: if wb_en and wb_dst equals the source address, the operand is wb_data, else RF[source].
REQ-018 A per-register busy bit SHALL be set the cycle after accepting a writer to dst, and cleared the cycle after wb_en to wb_dst; on same-register simultaneous set and clear, set SHALL win.
REQ-019 hazard SHALL be true when in_valid and (any used source is busy and not cleared by same-cycle wb, or the instruction writes and busy[dst] is set and not cleared by same-cycle wb).
REQ-020 stalled SHALL equal hazard; in_ready SHALL equal !hazard && !internal_reset && (!out_valid || out_ready).
REQ-021 On accept of a non-NOP, non-SRST instruction, the ID/EX register SHALL load next edge with out_valid=1 (latency one cycle).
REQ-022 While out_valid && !out_ready, all out_* SHALL hold stable; on out_ready without a new load, out_valid SHALL clear.
REQ-023 An accepted NOP SHALL consume the instruction without setting out_valid.
REQ-024 wb_en SHALL write RF[wb_dst] <= wb_data at the edge, independent of in_valid or stall.
REQ-025 Accepted SRST SHALL, next edge, zero all RF entries and busy bits, clear out_valid, and pulse internal_reset high for exactly one cycle; a same-cycle writeback SHALL be discarded.

Reset
REQ-026 reset=0 SHALL asynchronously zero RF, busy bits, out_valid, all out_* registers and internal_reset; in_ready SHALL be 1 after release when no hazard.

Verification
REQ-027 Reset, then ADD dst=2 src1=0 src2=1 with RF zero -> out_valid next cycle, dat1=dat2=0, aluop 0, wr_en 1, dst 2.
REQ-028 ADD dst=3 accepted, then SUB src1=3 with no writeback -> stalled=1, in_ready=0; wb_en dst=3 data=0x00A5 -> same cycle SUB accepted, out_dat1=0x00A5.
REQ-029 ADDI src1=1 imm=0x7FFF with out_ready=0 for 3 cycles -> outputs unchanged for 3 cycles, in_ready=0; out_ready=1 -> out_valid drops next cycle if no new input.
REQ-030 SRST with busy[4]=1 and simultaneous wb dst=5 -> next cycle internal_reset=1 one cycle, RF[5]=0, busy all 0, out_valid=0, in_ready=0 that cycle.
REQ-031 NREGS=32, DW=32: OUT src1=31 after wb 0xDEADBEEF to 31 -> out_dat1=0xDEADBEEF, dataoutv 1, wr_en 0.
REQ-032 reset pulled low mid-stall -> all outputs 0 immediately, busy cleared, stalled=0 after release.

Source files
------------

// File: rtl/decode_unit_param.sv
// Decode stage with register file, writeback bypass, busy-bit scoreboard,
// a single ID/EX output register with valid/ready handshake, and an
// instruction-triggered soft reset (SRST) that clears the architectural state.
module decode_unit_param #(
    parameter int DW    = 16,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    opcode,
    input  logic [AW-1:0] src1,
    input  logic [AW-1:0] src2,
    input  logic [AW-1:0] dst,
    input  logic [DW-1:0] imm,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_dat1,
    output logic [DW-1:0] out_dat2,
    output logic [AW-1:0] out_dst,
    output logic [1:0]    out_aluop,
    output logic          out_wr_en,
    output logic          out_dataoutv,
    output logic          stalled,
    output logic          internal_reset
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;
    localparam logic [2:0] OP_OUT  = 3'd6;
    localparam logic [2:0] OP_SRST = 3'd7;

    logic [DW-1:0]    rf_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             out_valid_q;
    logic [DW-1:0]    out_dat1_q;
    logic [DW-1:0]    out_dat2_q;
    logic [AW-1:0]    out_dst_q;
    logic [1:0]       out_aluop_q;
    logic             out_wr_en_q;
    logic             out_dataoutv_q;
    logic             internal_reset_q;

    logic             uses1_s;
    logic             uses2_s;
    logic             writes_s;
    logic             exec_s;
    logic [1:0]       aluop_s;
    logic             dataoutv_s;
    logic [DW-1:0]    opnd1_s;
    logic [DW-1:0]    opnd2_s;
    logic [DW-1:0]    dat2_s;
    logic [NREGS-1:0] clr_s;
    logic [NREGS-1:0] set_s;
    logic [NREGS-1:0] busy_eff_s;
    logic             hazard_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             srst_acc_s;
    logic             load_s;

    // Opcode decode: which sources are read, whether dst is written, ALU op.
    always_comb begin
        uses1_s    = 1'b0;
        uses2_s    = 1'b0;
        writes_s   = 1'b0;
        exec_s     = 1'b0;
        aluop_s    = 2'd0;
        dataoutv_s = 1'b0;
        case (opcode)
            OP_ADD:  begin uses1_s = 1'b1; uses2_s = 1'b1; writes_s = 1'b1; exec_s = 1'b1; aluop_s = 2'd0; end
            OP_SUB:  begin uses1_s = 1'b1; uses2_s = 1'b1; writes_s = 1'b1; exec_s = 1'b1; aluop_s = 2'd1; end
            OP_AND:  begin uses1_s = 1'b1; uses2_s = 1'b1; writes_s = 1'b1; exec_s = 1'b1; aluop_s = 2'd2; end
            OP_OR:   begin uses1_s = 1'b1; uses2_s = 1'b1; writes_s = 1'b1; exec_s = 1'b1; aluop_s = 2'd3; end
            OP_ADDI: begin uses1_s = 1'b1; writes_s = 1'b1; exec_s = 1'b1; aluop_s = 2'd0; end
            OP_OUT:  begin uses1_s = 1'b1; exec_s = 1'b1; aluop_s = 2'd3; dataoutv_s = 1'b1; end
            OP_NOP, OP_SRST: begin end
            default: begin end
        endcase
    end

    // Operand read with same-cycle writeback bypass; second operand muxing.
    always_comb begin
        if (wb_en && (wb_dst == src1)) begin
            opnd1_s = wb_data;
        end else begin
            opnd1_s = rf_q[src1];
        end
        if (wb_en && (wb_dst == src2)) begin
            opnd2_s = wb_data;
        end else begin
            opnd2_s = rf_q[src2];
        end
        case (opcode)
            OP_ADDI: dat2_s = imm;
            OP_OUT:  dat2_s = {DW{1'b0}};
            default: dat2_s = opnd2_s;
        endcase
    end

    // Scoreboard view: busy bits already cleared by this cycle's writeback.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            clr_s[i] = wb_en && (wb_dst == AW'(i));
        end
        busy_eff_s = busy_q & ~clr_s;
        if (in_valid) begin
            hazard_s = (uses1_s && busy_eff_s[src1]) ||
                       (uses2_s && busy_eff_s[src2]) ||
                       (writes_s && busy_eff_s[dst]);
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign in_ready_s = !hazard_s && !internal_reset_q && (!out_valid_q || out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign srst_acc_s = accept_s && (opcode == OP_SRST);
    assign load_s     = accept_s && exec_s;

    // Busy next-state: a new writer's set overrides a same-register clear.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            set_s[i] = accept_s && writes_s && (dst == AW'(i));
        end
        if (srst_acc_s) begin
            busy_d = {NREGS{1'b0}};
        end else begin
            busy_d = busy_eff_s | set_s;
        end
    end

    // Register file: writeback port, wiped by SRST (which also drops the writeback).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= {DW{1'b0}};
        end else if (srst_acc_s) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= {DW{1'b0}};
        end else if (wb_en) begin
            rf_q[wb_dst] <= wb_data;
        end else begin
            rf_q[wb_dst] <= rf_q[wb_dst];
        end
    end

    // Busy-bit scoreboard register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // ID/EX register: loads on accept, holds under backpressure, drains on out_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q    <= 1'b0;
            out_dat1_q     <= {DW{1'b0}};
            out_dat2_q     <= {DW{1'b0}};
            out_dst_q      <= {AW{1'b0}};
            out_aluop_q    <= 2'd0;
            out_wr_en_q    <= 1'b0;
            out_dataoutv_q <= 1'b0;
        end else if (srst_acc_s) begin
            out_valid_q    <= 1'b0;
        end else if (load_s) begin
            out_valid_q    <= 1'b1;
            out_dat1_q     <= opnd1_s;
            out_dat2_q     <= dat2_s;
            out_dst_q      <= dst;
            out_aluop_q    <= aluop_s;
            out_wr_en_q    <= writes_s;
            out_dataoutv_q <= dataoutv_s;
        end else if (out_ready) begin
            out_valid_q    <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_q;
        end
    end

    // One-cycle internal reset pulse following an accepted SRST.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            internal_reset_q <= 1'b0;
        end else begin
            internal_reset_q <= srst_acc_s;
        end
    end

    assign in_ready       = in_ready_s;
    assign stalled        = hazard_s;
    assign out_valid      = out_valid_q;
    assign out_dat1       = out_dat1_q;
    assign out_dat2       = out_dat2_q;
    assign out_dst        = out_dst_q;
    assign out_aluop      = out_aluop_q;
    assign out_wr_en      = out_wr_en_q;
    assign out_dataoutv   = out_dataoutv_q;
    assign internal_reset = internal_reset_q;

endmodule

// File: tb/tb_decode_unit_param.sv
// Self-checking bench for decode_unit_param: directed scenarios plus a
// randomized run against an instruction-level reference model.
module tb_decode_unit_param;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [2:0]  src1, src2, dst;
    logic [15:0] imm;
    logic        wb_en;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_dat1, out_dat2;
    logic [2:0]  out_dst;
    logic [1:0]  out_aluop;
    logic        out_wr_en, out_dataoutv, stalled, internal_reset;

    logic        w_in_valid, w_in_ready;
    logic [2:0]  w_opcode;
    logic [4:0]  w_src1, w_src2, w_dst, w_wb_dst, w_out_dst;
    logic [31:0] w_imm, w_wb_data, w_out_dat1, w_out_dat2;
    logic        w_wb_en, w_out_valid, w_out_ready;
    logic [1:0]  w_out_aluop;
    logic        w_out_wr_en, w_out_dataoutv, w_stalled, w_internal_reset;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (architectural view)
    logic [15:0] m_rf [8];
    bit          m_busy [8];
    bit          m_ov, m_wr, m_dov, m_ir;
    logic [15:0] m_d1, m_d2;
    logic [2:0]  m_dst;
    logic [1:0]  m_alu;

    decode_unit_param #(.DW(16), .NREGS(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .src1(src1), .src2(src2), .dst(dst), .imm(imm),
        .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dat1(out_dat1), .out_dat2(out_dat2), .out_dst(out_dst),
        .out_aluop(out_aluop), .out_wr_en(out_wr_en), .out_dataoutv(out_dataoutv),
        .stalled(stalled), .internal_reset(internal_reset)
    );

    decode_unit_param #(.DW(32), .NREGS(32)) dut_w (
        .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .opcode(w_opcode), .src1(w_src1), .src2(w_src2), .dst(w_dst), .imm(w_imm),
        .wb_en(w_wb_en), .wb_dst(w_wb_dst), .wb_data(w_wb_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_dat1(w_out_dat1), .out_dat2(w_out_dat2), .out_dst(w_out_dst),
        .out_aluop(w_out_aluop), .out_wr_en(w_out_wr_en), .out_dataoutv(w_out_dataoutv),
        .stalled(w_stalled), .internal_reset(w_internal_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit reads_a(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd6);
    endfunction
    function automatic bit reads_b(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction
    function automatic bit writes_reg(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction
    function automatic logic [1:0] alu_of(input logic [2:0] op);
        case (op)
            3'd2:    return 2'd1;
            3'd3:    return 2'd2;
            3'd4, 3'd6: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_rf[i] = 16'd0; m_busy[i] = 1'b0; end
        m_ov = 1'b0; m_wr = 1'b0; m_dov = 1'b0; m_ir = 1'b0;
        m_d1 = 16'd0; m_d2 = 16'd0; m_dst = 3'd0; m_alu = 2'd0;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; opcode = 3'd0; src1 = 3'd0; src2 = 3'd0; dst = 3'd0;
        imm = 16'd0; wb_en = 1'b0; wb_dst = 3'd0; wb_data = 16'd0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_opcode = 3'd0; w_src1 = 5'd0; w_src2 = 5'd0; w_dst = 5'd0;
        w_imm = 32'd0; w_wb_en = 1'b0; w_wb_dst = 5'd0; w_wb_data = 32'd0; w_out_ready = 1'b1;
    endtask

    // One clock of stimulus: check registered outputs against the model, apply
    // inputs, check handshake outputs, advance the model, return just after the edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] d, input logic [15:0] im,
                        input logic wbe, input logic [2:0] wbd, input logic [15:0] wbdat,
                        input logic ordy);
        bit hz, rdy, acc;
        logic [15:0] r1, r2;
        @(negedge clock);
        vectors++;
        if (out_valid !== m_ov) begin
            miscompares++; $display("FAIL out_valid: got %b want %b at %0t", out_valid, m_ov, $time);
        end
        vectors++;
        if (internal_reset !== m_ir) begin
            miscompares++; $display("FAIL internal_reset: got %b want %b at %0t", internal_reset, m_ir, $time);
        end
        if (m_ov) begin
            vectors++;
            if ({out_dat1, out_dat2, out_dst, out_aluop, out_wr_en, out_dataoutv} !==
                {m_d1, m_d2, m_dst, m_alu, m_wr, m_dov}) begin
                miscompares++;
                $display("FAIL idex_payload: got d1=%h d2=%h dst=%0d op=%0d wr=%b dov=%b want d1=%h d2=%h dst=%0d op=%0d wr=%b dov=%b at %0t",
                         out_dat1, out_dat2, out_dst, out_aluop, out_wr_en, out_dataoutv,
                         m_d1, m_d2, m_dst, m_alu, m_wr, m_dov, $time);
            end
        end
        in_valid = v; opcode = op; src1 = s1; src2 = s2; dst = d; imm = im;
        wb_en = wbe; wb_dst = wbd; wb_data = wbdat; out_ready = ordy;
        #1;
        hz = v && ((reads_a(op) && m_busy[s1] && !(wbe && wbd == s1)) ||
                   (reads_b(op) && m_busy[s2] && !(wbe && wbd == s2)) ||
                   (writes_reg(op) && m_busy[d] && !(wbe && wbd == d)));
        rdy = !hz && !m_ir && (!m_ov || ordy);
        acc = v && rdy;
        vectors++;
        if (stalled !== hz) begin
            miscompares++; $display("FAIL stalled: got %b want %b at %0t", stalled, hz, $time);
        end
        vectors++;
        if (in_ready !== rdy) begin
            miscompares++; $display("FAIL in_ready: got %b want %b at %0t", in_ready, rdy, $time);
        end
        r1 = (wbe && wbd == s1) ? wbdat : m_rf[s1];
        r2 = (wbe && wbd == s2) ? wbdat : m_rf[s2];
        if (acc && op == 3'd7) begin
            for (int i = 0; i < 8; i++) begin m_rf[i] = 16'd0; m_busy[i] = 1'b0; end
            m_ov = 1'b0; m_ir = 1'b1;
        end else begin
            m_ir = 1'b0;
            if (acc && reads_a(op)) begin
                m_ov = 1'b1; m_d1 = r1;
                m_d2 = (op == 3'd5) ? im : ((op == 3'd6) ? 16'd0 : r2);
                m_dst = d; m_alu = alu_of(op); m_wr = writes_reg(op); m_dov = (op == 3'd6);
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (wbe) begin m_rf[wbd] = wbdat; m_busy[wbd] = 1'b0; end
            if (acc && writes_reg(op)) m_busy[d] = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step_idle();
        step(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({out_valid, out_dat1, out_dat2, out_dst, out_aluop, out_wr_en, out_dataoutv, internal_reset} !== 40'd0) begin
            miscompares++; $display("FAIL reset_outputs: got v=%b d1=%h d2=%h ir=%b want all zero", out_valid, out_dat1, out_dat2, internal_reset);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || stalled !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready: got in_ready=%b stalled=%b want 1/0", in_ready, stalled);
        end
    endtask

    task automatic test_add_basic();
        test_reset();
        step(1'b1, 3'd1, 3'd0, 3'd1, 3'd2, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        vectors++;
        if ({out_valid, out_dat1, out_dat2, out_aluop, out_wr_en, out_dst} !== {1'b1, 16'd0, 16'd0, 2'd0, 1'b1, 3'd2}) begin
            miscompares++; $display("FAIL add_basic: got v=%b d1=%h d2=%h op=%0d wr=%b dst=%0d want 1/0/0/0/1/2",
                                    out_valid, out_dat1, out_dat2, out_aluop, out_wr_en, out_dst);
        end
        step_idle();
        step_idle();
    endtask

    task automatic test_hazard_bypass();
        test_reset();
        step(1'b1, 3'd1, 3'd0, 3'd1, 3'd3, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        step(1'b1, 3'd2, 3'd3, 3'd0, 3'd4, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        vectors++;
        if (stalled !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL raw_stall: got stalled=%b in_ready=%b want 1/0", stalled, in_ready);
        end
        step(1'b1, 3'd2, 3'd3, 3'd0, 3'd4, 16'd0, 1'b1, 3'd3, 16'h00A5, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_dat1 !== 16'h00A5 || out_aluop !== 2'd1) begin
            miscompares++; $display("FAIL wb_bypass: got v=%b d1=%h op=%0d want 1/00a5/1", out_valid, out_dat1, out_aluop);
        end
        step_idle();
        step_idle();
    endtask

    task automatic test_backpressure();
        test_reset();
        step(1'b1, 3'd5, 3'd1, 3'd0, 3'd5, 16'h7FFF, 1'b0, 3'd0, 16'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'd1, 3'd0, 3'd0, 3'd6, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
            vectors++;
            if ({out_valid, out_dat1, out_dat2, out_dst, out_aluop, out_wr_en, out_dataoutv, in_ready} !==
                {1'b1, 16'd0, 16'h7FFF, 3'd5, 2'd0, 1'b1, 1'b0, 1'b0}) begin
                miscompares++; $display("FAIL hold_cycle%0d: got v=%b d2=%h dst=%0d in_ready=%b want 1/7fff/5/0",
                                        k, out_valid, out_dat2, out_dst, in_ready);
            end
        end
        step_idle();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL drain: got out_valid=%b want 0", out_valid);
        end
        step_idle();
    endtask

    task automatic test_srst();
        test_reset();
        step(1'b1, 3'd1, 3'd0, 3'd0, 3'd4, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        step(1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 16'd0, 1'b1, 3'd5, 16'h1234, 1'b1);
        vectors++;
        if (internal_reset !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL srst_pulse: got ir=%b v=%b in_ready=%b want 1/0/0", internal_reset, out_valid, in_ready);
        end
        step_idle();
        vectors++;
        if (internal_reset !== 1'b0) begin
            miscompares++; $display("FAIL srst_width: got ir=%b want 0", internal_reset);
        end
        step(1'b1, 3'd1, 3'd5, 3'd4, 3'd4, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_dat1 !== 16'd0) begin
            miscompares++; $display("FAIL srst_clears: got v=%b d1=%h want 1/0000", out_valid, out_dat1);
        end
        step(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'd0, 1'b1, 3'd4, 16'd0, 1'b1);
        step_idle();
    endtask

    task automatic test_wide();
        @(negedge clock);
        w_wb_en = 1'b1; w_wb_dst = 5'd31; w_wb_data = 32'hDEADBEEF;
        @(negedge clock);
        w_wb_en = 1'b0;
        w_in_valid = 1'b1; w_opcode = 3'd6; w_src1 = 5'd31; w_dst = 5'd7;
        #1;
        vectors++;
        if (w_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL wide_ready: got %b want 1", w_in_ready);
        end
        @(posedge clock);
        #1;
        w_in_valid = 1'b0;
        vectors++;
        if ({w_out_valid, w_out_dat1, w_out_dat2, w_out_aluop, w_out_wr_en, w_out_dataoutv} !==
            {1'b1, 32'hDEADBEEF, 32'd0, 2'd3, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL wide_out: got v=%b d1=%h d2=%h op=%0d wr=%b dov=%b want 1/deadbeef/0/3/0/1",
                                    w_out_valid, w_out_dat1, w_out_dat2, w_out_aluop, w_out_wr_en, w_out_dataoutv);
        end
    endtask

    task automatic test_reset_mid_stall();
        test_reset();
        step(1'b1, 3'd1, 3'd0, 3'd0, 3'd3, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        step(1'b1, 3'd2, 3'd3, 3'd0, 3'd4, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({out_valid, out_dat1, out_dat2, out_dst, out_aluop, out_wr_en, out_dataoutv, internal_reset, stalled} !== 41'd0) begin
            miscompares++; $display("FAIL async_reset: got v=%b d1=%h stalled=%b want all zero", out_valid, out_dat1, stalled);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if (stalled !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_stall: got stalled=%b in_ready=%b want 0/1", stalled, in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [2:0] op;
        test_reset();
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd7 && $urandom_range(0, 7) != 0) op = 3'($urandom_range(1, 6));
            step(1'($urandom_range(0, 4) != 0), op, 3'($urandom), 3'($urandom), 3'($urandom),
                 16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end
        step_idle();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_add_basic();
        test_hazard_bypass();
        test_backpressure();
        test_srst();
        test_wide();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
